// File: rtl/calc_pkg.sv
// Shared definitions for the switch-calculator core: opcodes, FSM states and
// the flag bit ordering consumed by the LED/7-seg display driver.
package calc_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_MOD = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ALU  = 2'd1,
      ST_ITER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int FLG_OVF = 0;
   localparam int FLG_DZ  = 1;
   localparam int FLG_ERR = 2;
   localparam int FLG_W   = 3;

endpackage

// File: rtl/calc_iter_unit.sv
// Unsigned shift-add multiplier / restoring divider sharing one accumulator.
// The divider half exists only when CALC_DIV_EN is defined.
module calc_iter_unit #(
   parameter int WIDTH = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 mode_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 finish_o,
   output logic [2*WIDTH-1:0]   acc_o
);

   localparam int W  = WIDTH;
   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0] cnt_q;
   logic [RW-1:0] acc_q;
   logic [RW-1:0] acc_d;
   logic [RW-1:0] mul_nxt;
   logic [W-1:0]  b_q;
   logic [W:0]    msum;

   // Multiply: high half accumulates, product shifts right through the low half.
   assign msum    = {1'b0, acc_q[RW-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_nxt = {msum, acc_q[W-1:1]};

`ifdef CALC_DIV_EN
   logic          mode_q;
   logic [W:0]    trial;
   logic [W:0]    diff;
   logic [RW-1:0] div_nxt;

   // Divide: remainder in the high half, quotient bits shift into the low half.
   assign trial   = acc_q[RW-1:W-1];
   assign diff    = trial - {1'b0, b_q};
   assign div_nxt = diff[W] ? {trial[W-1:0], acc_q[W-2:0], 1'b0}
                            : {diff[W-1:0],  acc_q[W-2:0], 1'b1};
   assign acc_d   = mode_q ? div_nxt : mul_nxt;
`else
   logic unused_mode;
   assign unused_mode = mode_i;
   assign acc_d       = mul_nxt;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CW'(W);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i) begin
         acc_q <= {{W{1'b0}}, a_i};
         b_q   <= b_i;
`ifdef CALC_DIV_EN
         mode_q <= mode_i;
`endif
      end else if (cnt_q != '0) begin
         acc_q <= acc_d;
      end
   end

   assign finish_o = (cnt_q == CW'(1));
   assign acc_o    = acc_q;

endmodule

// File: rtl/calc_core_seq.sv
// Clocked WIDTH-bit calculator core with start/done handshake.
// Define CALC_DIV_EN to build the iterative DIV/MOD path.
module calc_core_seq
   import calc_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic                 Clk_100MHz,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [2:0]           opcode,
   input  logic                 op_signed,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy,
   output logic                 done,
   output logic                 ovf,
   output logic                 dz,
   output logic                 op_err
);

   localparam int W  = WIDTH;
   localparam int RW = 2 * WIDTH;

   state_t           state_q;
   logic [W-1:0]     a_q, b_q;
   logic [2:0]       opc_q;
   logic             sgn_q;
   logic [RW-1:0]    result_q;
   logic             busy_q, done_q;
   logic [FLG_W-1:0] flags_q;

   logic             iter_path, iter_load, iter_mode, iter_finish, iter_neg;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       ea, eb;
   logic [RW-1:0]    iter_acc, iter_mag;
   logic [RW-1:0]    alu_res_d, iter_res_d;
   logic [FLG_W-1:0] alu_flags_d, iter_flags_d;

   function automatic logic [RW-1:0] ext_w1(input logic [W:0] v, input logic s);
      return {{(RW-W-1){s & v[W]}}, v};
   endfunction

   function automatic logic [RW-1:0] ext_w(input logic [W-1:0] v, input logic s);
      return {{(RW-W){s & v[W-1]}}, v};
   endfunction

   function automatic logic fits_w(input logic [RW-1:0] v, input logic s);
      if (s) return (&v[RW-1:W-1]) | ~(|v[RW-1:W-1]);
      return ~(|v[RW-1:W]);
   endfunction

   function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
      return (s & v[W-1]) ? -v : v;
   endfunction

`ifdef CALC_DIV_EN
   assign iter_path = (opcode == OP_MUL) ||
                      (((opcode == OP_DIV) || (opcode == OP_MOD)) && (op_b != '0));
`else
   assign iter_path = (opcode == OP_MUL);
`endif
   assign iter_load = (state_q == ST_IDLE) && start && iter_path;
   assign iter_mode = (opcode != OP_MUL);
   assign mag_a     = mag(op_a, op_signed);
   assign mag_b     = mag(op_b, op_signed);

   calc_iter_unit #(.WIDTH(W)) u_iter (
      .clk_i    (Clk_100MHz),
      .rst_i    (Reset),
      .load_i   (iter_load),
      .mode_i   (iter_mode),
      .a_i      (mag_a),
      .b_i      (mag_b),
      .finish_o (iter_finish),
      .acc_o    (iter_acc)
   );

   assign ea = {sgn_q & a_q[W-1], a_q};
   assign eb = {sgn_q & b_q[W-1], b_q};

   always_comb begin
      alu_res_d   = '0;
      alu_flags_d = '0;
      case (opc_q)
         OP_ADD: alu_res_d = ext_w1(ea + eb, sgn_q);
         OP_SUB: alu_res_d = ext_w1(ea - eb, sgn_q);
         OP_AND: alu_res_d = {{(RW-W){1'b0}}, a_q & b_q};
         OP_OR:  alu_res_d = {{(RW-W){1'b0}}, a_q | b_q};
         OP_XOR: alu_res_d = {{(RW-W){1'b0}}, a_q ^ b_q};
`ifdef CALC_DIV_EN
         // Only divide-by-zero reaches the ALU state for DIV/MOD.
         OP_DIV: begin
            alu_res_d           = {{(RW-W){1'b0}}, {W{1'b1}}};
            alu_flags_d[FLG_DZ] = 1'b1;
         end
         OP_MOD: begin
            alu_res_d           = ext_w(a_q, sgn_q);
            alu_flags_d[FLG_DZ] = 1'b1;
         end
`else
         OP_DIV, OP_MOD: alu_flags_d[FLG_ERR] = 1'b1;
`endif
         default: alu_res_d = '0;
      endcase
      if ((opc_q == OP_ADD) || (opc_q == OP_SUB))
         alu_flags_d[FLG_OVF] = ~fits_w(alu_res_d, sgn_q);
   end

   always_comb begin
      iter_mag = iter_acc;
      iter_neg = sgn_q & (a_q[W-1] ^ b_q[W-1]);
`ifdef CALC_DIV_EN
      if (opc_q == OP_DIV) begin
         iter_mag = {{(RW-W){1'b0}}, iter_acc[W-1:0]};
      end else if (opc_q == OP_MOD) begin
         iter_mag = {{(RW-W){1'b0}}, iter_acc[RW-1:W]};
         iter_neg = sgn_q & a_q[W-1];
      end
`endif
      iter_res_d            = iter_neg ? -iter_mag : iter_mag;
      iter_flags_d          = '0;
      iter_flags_d[FLG_OVF] = ~fits_w(iter_res_d, sgn_q);
   end

   always_ff @(posedge Clk_100MHz) begin
      if ((state_q == ST_IDLE) && start) begin
         a_q   <= op_a;
         b_q   <= op_b;
         opc_q <= opcode;
         sgn_q <= op_signed;
      end
   end

   always_ff @(posedge Clk_100MHz or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         flags_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start) begin
               busy_q  <= 1'b1;
               flags_q <= '0;
               state_q <= iter_path ? ST_ITER : ST_ALU;
            end
            ST_ALU: begin
               result_q <= alu_res_d;
               flags_q  <= alu_flags_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            ST_ITER: if (iter_finish) state_q <= ST_DONE;
            ST_DONE: begin
               result_q <= iter_res_d;
               flags_q  <= iter_flags_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign ovf    = flags_q[FLG_OVF];
   assign dz     = flags_q[FLG_DZ];
   assign op_err = flags_q[FLG_ERR];

endmodule

// File: tb/tb_calc_core_seq.sv
// Bench for calc_core_seq (WIDTH=6): directed table, handshake/reset sequences
// and randomized operations against an integer-arithmetic reference model.
module tb_calc_core_seq;

   localparam int WIDTH = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  opcode = 3'd0;
   logic        op_signed = 1'b0;
   logic [5:0]  op_a = 6'd0;
   logic [5:0]  op_b = 6'd0;
   logic [11:0] result;
   logic        busy, done, ovf, dz, op_err;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]  opc;
      logic        sgn;
      logic [5:0]  a;
      logic [5:0]  b;
      logic [11:0] res;
      logic        ovf;
      logic        dz;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   calc_core_seq #(.WIDTH(WIDTH)) dut (
      .Clk_100MHz (clk),
      .Reset      (rst),
      .start      (start),
      .opcode     (opcode),
      .op_signed  (op_signed),
      .op_a       (op_a),
      .op_b       (op_b),
      .result     (result),
      .busy       (busy),
      .done       (done),
      .ovf        (ovf),
      .dz         (dz),
      .op_err     (op_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int sval(input logic [5:0] v, input logic s);
      if (s && v[5]) return int'(v) - 64;
      return int'(v);
   endfunction

   function automatic bit inrange(input int v, input logic s);
      if (s) return (v >= -32) && (v <= 31);
      return (v >= 0) && (v <= 63);
   endfunction

   function automatic void model(input logic [2:0] opc, input logic s,
                                 input logic [5:0] a, input logic [5:0] b,
                                 output logic [11:0] r, output logic o,
                                 output logic d, output logic e, output int lat);
      int av, bv, v;
      av = sval(a, s);
      bv = sval(b, s);
      r = 12'd0; o = 1'b0; d = 1'b0; e = 1'b0; lat = 1;
      case (opc)
         3'd0, 3'd1: begin
            v = (opc == 3'd0) ? av + bv : av - bv;
            r = s ? 12'(v) : 12'(v & 127);
            o = !inrange(v, s);
         end
         3'd2: r = {6'd0, a & b};
         3'd3: r = {6'd0, a | b};
         3'd4: r = {6'd0, a ^ b};
         3'd5: begin
            v = av * bv;
            r = 12'(v);
            o = !inrange(v, s);
            lat = WIDTH + 1;
         end
         default: begin
`ifdef CALC_DIV_EN
            if (b == 6'd0) begin
               d = 1'b1;
               r = (opc == 3'd6) ? 12'd63 : 12'(av);
            end else begin
               v = (opc == 3'd6) ? av / bv : av % bv;
               r = 12'(v);
               o = !inrange(v, s);
               lat = WIDTH + 1;
            end
`else
            e = 1'b1;
`endif
         end
      endcase
   endfunction

   task automatic add_vec(input logic [2:0] opc, input logic s, input logic [5:0] a,
                          input logic [5:0] b, input logic [11:0] r, input logic o,
                          input logic d, input logic e, input int lat);
      vec_t v;
      v.opc = opc; v.sgn = s; v.a = a; v.b = b;
      v.res = r; v.ovf = o; v.dz = d; v.err = e; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic run_op(input string tag, input logic [2:0] opc, input logic s,
                         input logic [5:0] a, input logic [5:0] b, input logic [11:0] er,
                         input logic eo, input logic ed, input logic ee, input int el);
      int n;
      @(negedge clk);
      opcode = opc; op_signed = s; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, " busy_at_accept"}, busy, 1);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, " latency"}, n, el);
      chk({tag, " result"}, result, er);
      chk({tag, " ovf"}, ovf, eo);
      chk({tag, " dz"}, dz, ed);
      chk({tag, " op_err"}, op_err, ee);
      chk({tag, " busy_at_done"}, busy, 0);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      logic [11:0] r;
      logic        o, d, e;
      int          lat, n, m, dcount, first;
      logic [2:0]  ropc;
      logic        rs;
      logic [5:0]  ra, rb;

      add_vec(3'd0, 1'b0, 6'd45,   6'd30,   12'h04B, 1'b1, 1'b0, 1'b0, 1);
      add_vec(3'd1, 1'b1, 6'd3,    6'd5,    12'hFFE, 1'b0, 1'b0, 1'b0, 1);
      add_vec(3'd1, 1'b0, 6'd3,    6'd5,    12'h07E, 1'b1, 1'b0, 1'b0, 1);
      add_vec(3'd1, 1'b1, 6'h20,   6'd1,    12'hFDF, 1'b1, 1'b0, 1'b0, 1);
      add_vec(3'd0, 1'b1, 6'd31,   6'd1,    12'h020, 1'b1, 1'b0, 1'b0, 1);
      add_vec(3'd2, 1'b0, 6'h2A,   6'h0F,   12'h00A, 1'b0, 1'b0, 1'b0, 1);
      add_vec(3'd3, 1'b0, 6'h30,   6'h05,   12'h035, 1'b0, 1'b0, 1'b0, 1);
      add_vec(3'd4, 1'b1, 6'h3F,   6'h15,   12'h02A, 1'b0, 1'b0, 1'b0, 1);
      add_vec(3'd5, 1'b0, 6'd63,   6'd63,   12'hF81, 1'b1, 1'b0, 1'b0, 7);
      add_vec(3'd5, 1'b1, 6'h20,   6'h20,   12'h400, 1'b1, 1'b0, 1'b0, 7);
      add_vec(3'd5, 1'b1, 6'h3D,   6'd5,    12'hFF1, 1'b0, 1'b0, 1'b0, 7);
`ifdef CALC_DIV_EN
      add_vec(3'd6, 1'b1, 6'h27,   6'd7,    12'hFFD, 1'b0, 1'b0, 1'b0, 7);
      add_vec(3'd7, 1'b1, 6'h27,   6'd7,    12'hFFC, 1'b0, 1'b0, 1'b0, 7);
      add_vec(3'd6, 1'b0, 6'd45,   6'd7,    12'h006, 1'b0, 1'b0, 1'b0, 7);
      add_vec(3'd7, 1'b0, 6'd45,   6'd7,    12'h003, 1'b0, 1'b0, 1'b0, 7);
      add_vec(3'd6, 1'b0, 6'd13,   6'd0,    12'h03F, 1'b0, 1'b1, 1'b0, 1);
      add_vec(3'd7, 1'b0, 6'd13,   6'd0,    12'h00D, 1'b0, 1'b1, 1'b0, 1);
      add_vec(3'd6, 1'b1, 6'h20,   6'h3F,   12'h020, 1'b1, 1'b0, 1'b0, 7);
`else
      add_vec(3'd6, 1'b0, 6'd45,   6'd7,    12'h000, 1'b0, 1'b0, 1'b1, 1);
      add_vec(3'd7, 1'b1, 6'h27,   6'd7,    12'h000, 1'b0, 1'b0, 1'b1, 1);
      add_vec(3'd6, 1'b0, 6'd13,   6'd0,    12'h000, 1'b0, 1'b0, 1'b1, 1);
`endif

      // Reset and idle state
      #1 rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("reset result", result, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset ovf", ovf, 0);
      chk("reset dz", dz, 0);
      chk("reset op_err", op_err, 0);
      @(negedge clk) rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].opc, vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].ovf, vecs[i].dz, vecs[i].err, vecs[i].lat);

      // start pulsed during a MUL is ignored
      @(negedge clk);
      opcode = 3'd5; op_signed = 1'b0; op_a = 6'd7; op_b = 6'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dcount = 0; first = 0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            opcode = 3'd0; op_a = 6'd1; op_b = 6'd2; start = 1'b1;
         end
         if (k == 2) start = 1'b0;
         if (done === 1'b1) begin
            dcount++;
            if (first == 0) first = k;
         end
      end
      chk("ignore_start done_count", dcount, 1);
      chk("ignore_start done_edge", first, 7);
      chk("ignore_start result", result, 12'h03F);

      // start held high re-triggers after every completion
      @(negedge clk);
      opcode = 3'd0; op_signed = 1'b0; op_a = 6'd1; op_b = 6'd2; start = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("retrigger first", n, 2);
      m = 0;
      do begin
         @(posedge clk); #1;
         m++;
      end while (done !== 1'b1 && m < 10);
      start = 1'b0;
      chk("retrigger spacing", m, 2);
      chk("retrigger result", result, 12'h003);
      @(posedge clk); @(posedge clk); #1;

      // Reset in the middle of a MUL aborts it
      run_op("pre_reset", 3'd0, 1'b0, 6'd5, 6'd6, 12'h00B, 1'b0, 1'b0, 1'b0, 1);
      @(negedge clk);
      opcode = 3'd5; op_signed = 1'b0; op_a = 6'd9; op_b = 6'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("midreset busy_before", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("midreset result", result, 0);
      chk("midreset busy", busy, 0);
      chk("midreset done", done, 0);
      chk("midreset ovf", ovf, 0);
      chk("midreset dz", dz, 0);
      chk("midreset op_err", op_err, 0);
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) dcount++;
      end
      chk("midreset no_done", dcount, 0);
      run_op("post_reset", 3'd0, 1'b0, 6'd2, 6'd3, 12'h005, 1'b0, 1'b0, 1'b0, 1);

      // Randomized operations against the reference model
      for (int i = 0; i < 150; i++) begin
         ropc = 3'($urandom_range(0, 7));
         rs   = 1'($urandom_range(0, 1));
         ra   = 6'($urandom);
         rb   = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
         model(ropc, rs, ra, rb, r, o, d, e, lat);
         run_op($sformatf("rnd%0d op%0d s%0d %0h,%0h", i, ropc, rs, ra, rb),
                ropc, rs, ra, rb, r, o, d, e, lat);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
